// File: rtl/gb80_pkg.sv
// gb80_pkg: shared encodings for the GB80 8-bit ALU and the
// 16-bit op sequencer that drives it.
package gb80_pkg;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_ADC = 3'b001;
  localparam logic [2:0] ALU_SUB = 3'b010;
  localparam logic [2:0] ALU_SBC = 3'b011;
  localparam logic [2:0] ALU_AND = 3'b100;
  localparam logic [2:0] ALU_XOR = 3'b101;
  localparam logic [2:0] ALU_OR  = 3'b110;
  localparam logic [2:0] ALU_CP  = 3'b111;

  typedef logic [1:0] op16_t;
  localparam op16_t OP_ADD16  = 2'b00;
  localparam op16_t OP_SUB16  = 2'b01;
  localparam op16_t OP_ADD_E8 = 2'b10;
  localparam op16_t OP_RSV    = 2'b11;

  localparam int FLAG_Z  = 3;
  localparam int FLAG_N  = 2;
  localparam int FLAG_H  = 1;
  localparam int FLAG_CY = 0;

  typedef logic [2:0] seq_state_t;
  localparam seq_state_t S_IDLE = 3'd0;
  localparam seq_state_t S_LO   = 3'd1;
  localparam seq_state_t S_HI   = 3'd2;
  localparam seq_state_t S_WB   = 3'd3;
  localparam seq_state_t S_DONE = 3'd4;

endpackage

// File: rtl/alu16_seq_if.sv
// alu16_seq_if: byte-wide link between the sequencer and the
// 8-bit ALU (operands/control out, registered result back).
interface alu16_seq_if;

  logic [7:0] alu_a;
  logic [7:0] alu_b;
  logic [2:0] alu_control;
  logic [7:0] alu_data;
  logic [3:0] alu_flags;

  modport master (
    output alu_a,
    output alu_b,
    output alu_control,
    input  alu_data,
    input  alu_flags
  );

  modport slave (
    input  alu_a,
    input  alu_b,
    input  alu_control,
    output alu_data,
    output alu_flags
  );

endinterface

// File: rtl/gb80_alu8.sv
// gb80_alu8: 8-bit ALU with registered result/flags {Z,N,H,CY}
// and an internally held carry consumed by ADC/SBC.
module gb80_alu8
  import gb80_pkg::*;
(
  input  logic       i_clk,
  input  logic       i_rst,
  alu16_seq_if.slave bus
);

  logic       carry_q;
  logic       cin;
  logic       sub;
  logic [8:0] full;
  logic [4:0] half;
  logic [7:0] data_d;
  logic [3:0] flags_d;

  always_comb begin
    cin = 1'b0;
    sub = 1'b0;
    unique case (bus.alu_control)
      ALU_ADC: cin = carry_q;
      ALU_SUB: sub = 1'b1;
      ALU_CP:  sub = 1'b1;
      ALU_SBC: begin
        sub = 1'b1;
        cin = carry_q;
      end
      default: ;
    endcase
    if (sub) begin
      full = {1'b0, bus.alu_a}
           - {1'b0, bus.alu_b}
           - {8'd0, cin};
      half = {1'b0, bus.alu_a[3:0]}
           - {1'b0, bus.alu_b[3:0]}
           - {4'd0, cin};
    end else begin
      full = {1'b0, bus.alu_a}
           + {1'b0, bus.alu_b}
           + {8'd0, cin};
      half = {1'b0, bus.alu_a[3:0]}
           + {1'b0, bus.alu_b[3:0]}
           + {4'd0, cin};
    end
    data_d           = full[7:0];
    flags_d          = 4'b0;
    flags_d[FLAG_N]  = sub;
    flags_d[FLAG_H]  = half[4];
    flags_d[FLAG_CY] = full[8];
    unique case (bus.alu_control)
      ALU_AND: begin
        data_d           = bus.alu_a & bus.alu_b;
        flags_d[FLAG_H]  = 1'b1;
        flags_d[FLAG_CY] = 1'b0;
      end
      ALU_XOR: begin
        data_d           = bus.alu_a ^ bus.alu_b;
        flags_d[FLAG_H]  = 1'b0;
        flags_d[FLAG_CY] = 1'b0;
      end
      ALU_OR: begin
        data_d           = bus.alu_a | bus.alu_b;
        flags_d[FLAG_H]  = 1'b0;
        flags_d[FLAG_CY] = 1'b0;
      end
      default: ;
    endcase
    flags_d[FLAG_Z] = (data_d == 8'd0);
    // CP keeps the compare flags but returns A untouched
    if (bus.alu_control == ALU_CP) begin
      data_d = bus.alu_a;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      bus.alu_data  <= '0;
      bus.alu_flags <= '0;
      carry_q       <= 1'b0;
    end else begin
      bus.alu_data  <= data_d;
      bus.alu_flags <= flags_d;
      carry_q       <= flags_d[FLAG_CY];
    end
  end

endmodule

// File: rtl/alu16_seq.sv
// alu16_seq: runs 16-bit ADD16/SUB16/ADD_E8 as two byte ops on
// the 8-bit ALU. Define ALU16_SEQ_SUB_EN to enable SUB16.
module alu16_seq
  import gb80_pkg::*;
#(
  parameter int OPCODE_WIDTH = 3,
  parameter int DATA_WIDTH   = 8
) (
  input  logic                    i_clk,
  input  logic                    i_rst,
  input  logic                    i_valid,
  output logic                    o_ready,
  input  logic [1:0]              i_op,
  input  logic [2*DATA_WIDTH-1:0] i_a,
  input  logic [2*DATA_WIDTH-1:0] i_b,
  input  logic                    i_z_prev,
  output logic [DATA_WIDTH-1:0]   o_alu_a,
  output logic [DATA_WIDTH-1:0]   o_alu_b,
  output logic [OPCODE_WIDTH-1:0] o_alu_control,
  input  logic [DATA_WIDTH-1:0]   i_alu_data,
  input  logic [3:0]              i_alu_flags,
  output logic                    o_valid,
  output logic [2*DATA_WIDTH-1:0] o_result,
  output logic [3:0]              o_flags,
  output logic                    o_err
);

  localparam int D = DATA_WIDTH;
  localparam int W = 2 * DATA_WIDTH;

  seq_state_t   state;
  op16_t        op_q;
  logic [W-1:0] a_q;
  logic [W-1:0] b_q;
  logic         z_q;
  logic [D-1:0] lo_q;
  logic         lo_z_q;
  logic         lo_h_q;
  logic         lo_c_q;
  logic         rsv;
  logic         is_sub;
  logic         is_e8;
  logic [3:0]   wb_flags;

  always_comb begin
`ifdef ALU16_SEQ_SUB_EN
    rsv = (i_op == OP_RSV);
`else
    rsv = (i_op == OP_RSV)
       || (i_op == OP_SUB16);
`endif
  end

  assign is_sub  = (op_q == OP_SUB16);
  assign is_e8   = (op_q == OP_ADD_E8);
  assign o_ready = (state == S_IDLE);
  assign o_valid = (state == S_DONE);

  always_comb begin
    wb_flags = 4'b0;
    unique case (1'b1)
      is_e8: begin
        wb_flags[FLAG_H]  = lo_h_q;
        wb_flags[FLAG_CY] = lo_c_q;
      end
      is_sub: begin
        // 16-bit zero is both byte results zero
        wb_flags[FLAG_Z]  = lo_z_q
                          & i_alu_flags[FLAG_Z];
        wb_flags[FLAG_N]  = i_alu_flags[FLAG_N];
        wb_flags[FLAG_H]  = i_alu_flags[FLAG_H];
        wb_flags[FLAG_CY] = i_alu_flags[FLAG_CY];
      end
      default: begin
        wb_flags[FLAG_Z]  = z_q;
        wb_flags[FLAG_H]  = i_alu_flags[FLAG_H];
        wb_flags[FLAG_CY] = i_alu_flags[FLAG_CY];
      end
    endcase
  end

  always_comb begin
    o_alu_a       = '0;
    o_alu_b       = '0;
    o_alu_control = OPCODE_WIDTH'(ALU_ADD);
    unique case (1'b1)
      state == S_LO: begin
        o_alu_a = a_q[D-1:0];
        o_alu_b = b_q[D-1:0];
        o_alu_control = OPCODE_WIDTH'(
          is_sub ? ALU_SUB : ALU_ADD);
      end
      state == S_HI: begin
        o_alu_a = a_q[W-1:D];
        o_alu_b = is_e8 ? {D{b_q[D-1]}}
                        : b_q[W-1:D];
        o_alu_control = OPCODE_WIDTH'(
          is_sub ? ALU_SBC : ALU_ADC);
      end
      default: ;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state    <= S_IDLE;
      op_q     <= OP_ADD16;
      a_q      <= '0;
      b_q      <= '0;
      z_q      <= 1'b0;
      lo_q     <= '0;
      lo_z_q   <= 1'b0;
      lo_h_q   <= 1'b0;
      lo_c_q   <= 1'b0;
      o_result <= '0;
      o_flags  <= 4'b0;
      o_err    <= 1'b0;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (i_valid) begin
            op_q <= i_op;
            a_q  <= i_a;
            b_q  <= i_b;
            z_q  <= i_z_prev;
            if (rsv) begin
              state    <= S_DONE;
              o_result <= i_a;
              o_flags  <= {i_z_prev, 3'b000};
              o_err    <= 1'b1;
            end else begin
              state <= S_LO;
            end
          end
        end
        S_LO: state <= S_HI;
        S_HI: begin
          lo_q   <= i_alu_data;
          lo_z_q <= i_alu_flags[FLAG_Z];
          lo_h_q <= i_alu_flags[FLAG_H];
          lo_c_q <= i_alu_flags[FLAG_CY];
          state  <= S_WB;
        end
        S_WB: begin
          o_result <= {i_alu_data, lo_q};
          o_flags  <= wb_flags;
          o_err    <= 1'b0;
          state    <= S_DONE;
        end
        S_DONE: state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu16_seq.sv
// tb_alu16_seq: sequencer plus 8-bit ALU, random and directed
// requests scored against an arithmetic reference model.
module tb_alu16_seq;

  logic        i_clk    = 1'b0;
  logic        i_rst    = 1'b1;
  logic        i_valid  = 1'b0;
  logic [1:0]  i_op     = 2'b00;
  logic [15:0] i_a      = 16'h0;
  logic [15:0] i_b      = 16'h0;
  logic        i_z_prev = 1'b0;
  logic        o_ready;
  logic        o_valid;
  logic [15:0] o_result;
  logic [3:0]  o_flags;
  logic        o_err;

  typedef struct {
    logic [15:0] r;
    logic [3:0]  f;
    logic        e;
    int          due;
  } exp_t;

  exp_t sbq[$];
  int   checks   = 0;
  int   failures = 0;
  int   cyc      = 0;

  alu16_seq_if link();

  alu16_seq u_dut (
    .i_clk        (i_clk),
    .i_rst        (i_rst),
    .i_valid      (i_valid),
    .o_ready      (o_ready),
    .i_op         (i_op),
    .i_a          (i_a),
    .i_b          (i_b),
    .i_z_prev     (i_z_prev),
    .o_alu_a      (link.alu_a),
    .o_alu_b      (link.alu_b),
    .o_alu_control(link.alu_control),
    .i_alu_data   (link.alu_data),
    .i_alu_flags  (link.alu_flags),
    .o_valid      (o_valid),
    .o_result     (o_result),
    .o_flags      (o_flags),
    .o_err        (o_err)
  );

  gb80_alu8 u_alu (
    .i_clk(i_clk),
    .i_rst(i_rst),
    .bus  (link.slave)
  );

  always #5 i_clk = ~i_clk;
  always @(posedge i_clk) cyc++;

  task automatic check(input string name,
                       input logic [31:0] act,
                       input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h",
               name, act, req);
    end
  endtask

  task automatic flag_fail(input string name);
    checks++;
    failures++;
    $display("FAIL %s actual=timeout required=event", name);
  endtask

  // Reference: whole 16-bit arithmetic, flags from bit positions
  function automatic exp_t model(input logic [1:0]  op,
                                 input logic [15:0] a,
                                 input logic [15:0] b,
                                 input logic        z,
                                 input int          acc);
    exp_t e;
    int unsigned ua;
    int unsigned ub;
    int unsigned s;
    logic signed [7:0] e8;
    logic rsv;
    ua  = 32'(a);
    ub  = 32'(b);
    rsv = (op == 2'b11);
`ifndef ALU16_SEQ_SUB_EN
    if (op == 2'b01) rsv = 1'b1;
`endif
    e.r   = 16'h0;
    e.f   = 4'h0;
    e.e   = 1'b0;
    e.due = acc + 4;
    if (rsv) begin
      e.r   = a;
      e.f   = {z, 3'b000};
      e.e   = 1'b1;
      e.due = acc + 1;
    end else if (op == 2'b00) begin
      s   = ua + ub;
      e.r = s[15:0];
      e.f = {z, 1'b0,
             ((ua & 32'hFFF) + (ub & 32'hFFF)) > 32'hFFF,
             s > 32'hFFFF};
    end else if (op == 2'b01) begin
      s   = ua - ub;
      e.r = s[15:0];
      e.f = {s[15:0] == 16'h0, 1'b1,
             (ua & 32'hFFF) < (ub & 32'hFFF),
             ua < ub};
    end else begin
      e8  = b[7:0];
      s   = ua + 32'(e8);
      e.r = s[15:0];
      e.f = {2'b00,
             ((ua & 32'hF) + (ub & 32'hF)) > 32'hF,
             ((ua & 32'hFF) + (ub & 32'hFF)) > 32'hFF};
    end
    return e;
  endfunction

  always @(negedge i_clk) begin : mon
    exp_t e;
    if (o_valid) begin
      if (sbq.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_valid actual=1 required=0");
      end else begin
        e = sbq.pop_front();
        check("result", 32'(o_result), 32'(e.r));
        check("flags", 32'(o_flags), 32'(e.f));
        check("err", 32'(o_err), 32'(e.e));
        check("latency", 32'(cyc + 1), 32'(e.due));
      end
      check("done_alu_bus",
            32'({link.alu_control, link.alu_a, link.alu_b}),
            32'h0);
    end
  end

  task automatic issue(input logic [1:0]  op,
                       input logic [15:0] a,
                       input logic [15:0] b,
                       input logic        z);
    int n = 0;
    @(negedge i_clk);
    while (!o_ready && n < 20) begin
      @(negedge i_clk);
      n++;
    end
    if (!o_ready) begin
      flag_fail("ready_timeout");
      return;
    end
    i_op     = op;
    i_a      = a;
    i_b      = b;
    i_z_prev = z;
    i_valid  = 1'b1;
    sbq.push_back(model(op, a, b, z, cyc + 1));
    @(posedge i_clk);
    #1;
    i_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (sbq.size() != 0 && n < 40) begin
      @(negedge i_clk);
      n++;
    end
    if (sbq.size() != 0) begin
      flag_fail("drain_timeout");
      sbq.delete();
    end
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_ready"}, 32'(o_ready), 32'h1);
    check({tag, "_valid"}, 32'(o_valid), 32'h0);
    check({tag, "_result"}, 32'(o_result), 32'h0);
    check({tag, "_flags"}, 32'(o_flags), 32'h0);
    check({tag, "_err"}, 32'(o_err), 32'h0);
    check({tag, "_alu_bus"},
          32'({link.alu_control, link.alu_a, link.alu_b}),
          32'h0);
  endtask

  initial begin : wdog
    #500000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog");
  end

  initial begin : main
    int n1;
    int n2;
    int low;
    repeat (3) @(negedge i_clk);
    i_rst = 1'b0;
    check_reset_values("reset");

    issue(2'b00, 16'h0FFF, 16'h0001, 1'b1);
    issue(2'b00, 16'hFFFF, 16'h0001, 1'b0);
    issue(2'b10, 16'hFFF8, 16'h0008, 1'b0);
    issue(2'b10, 16'h0005, 16'h00FF, 1'b1);
    issue(2'b01, 16'h0001, 16'h0001, 1'b0);
    issue(2'b01, 16'h1234, 16'h2345, 1'b1);
    issue(2'b11, 16'hBEEF, 16'h1111, 1'b1);
    issue(2'b10, 16'h0000, 16'h0080, 1'b0);
    drain();

    for (int i = 0; i < 150; i++) begin
      repeat ($urandom_range(0, 2)) @(negedge i_clk);
      issue(2'($urandom_range(0, 3)), 16'($urandom),
            16'($urandom), 1'($urandom));
    end
    drain();

    // i_valid held high across two back-to-back requests
    @(negedge i_clk);
    i_op     = 2'b00;
    i_a      = 16'h1234;
    i_b      = 16'h4321;
    i_z_prev = 1'b0;
    i_valid  = 1'b1;
    n1 = cyc + 1;
    sbq.push_back(model(2'b00, 16'h1234, 16'h4321, 1'b0, n1));
    @(posedge i_clk);
    #1;
    i_a = 16'h8000;
    i_b = 16'h8001;
    low = 0;
    @(negedge i_clk);
    while (!o_ready && low < 10) begin
      low++;
      @(negedge i_clk);
    end
    check("b2b_ready_low", 32'(low), 32'd4);
    n2 = cyc + 1;
    sbq.push_back(model(2'b00, 16'h8000, 16'h8001, 1'b0, n2));
    check("b2b_spacing", 32'(n2 - n1), 32'd5);
    @(posedge i_clk);
    #1;
    i_valid = 1'b0;
    drain();

    // abort a request in HI; it must never complete
    @(negedge i_clk);
    i_op     = 2'b00;
    i_a      = 16'h7777;
    i_b      = 16'h1111;
    i_z_prev = 1'b1;
    i_valid  = 1'b1;
    @(posedge i_clk);
    #1;
    i_valid = 1'b0;
    @(posedge i_clk);
    #1;
    i_rst = 1'b1;
    @(posedge i_clk);
    #1;
    i_rst = 1'b0;
    @(negedge i_clk);
    check_reset_values("abort");
    repeat (10) @(negedge i_clk);

    issue(2'b00, 16'h00FF, 16'h0001, 1'b0);
    drain();

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule

// File: doc/alu16_seq.md
ALU16_SEQ -- requirements
Module: alu16_seq

Interface
REQ-001 The block SHALL have parameter OPCODE_WIDTH, default 3, meaning the width of the 8-bit ALU control bus it drives.
REQ-002 The block SHALL have parameter DATA_WIDTH, default 8, meaning the byte width of the 8-bit ALU; the operand width is 2*DATA_WIDTH.
REQ-003 The block SHALL have one clock and one reset: i_clk  in  1  clock; i_rst  in  1  reset, synchronous, active-high.
REQ-004 The block SHALL have i_valid  in  1  request valid.
REQ-005 The block SHALL have o_ready  out  1  request accepted when high together with i_valid.
REQ-006 The block SHALL have i_op  in  2  operation: 00 ADD16, 01 SUB16, 10 ADD_E8, 11 reserved.
REQ-007 The block SHALL have i_a  in  16  first operand (HL/SP).
REQ-008 The block SHALL have i_b  in  16  second operand; ADD_E8 uses i_b[7:0] as signed.
REQ-009 The block SHALL have i_z_prev  in  1  current Z flag, preserved by ADD16.
REQ-010 The block SHALL have the ALU-facing ports o_alu_a  out  8, o_alu_b  out  8 and o_alu_control  out  3, which drive the ALU.
REQ-011 The block SHALL have the ALU return ports i_alu_data  in  8 and i_alu_flags  in  4 {Z,N,H,CY}, registered by the ALU one cycle after control is presented.
REQ-012 The block SHALL have the result ports o_valid  out  1 (one-cycle done pulse), o_result  out  16, o_flags  out  4 {Z,N,H,CY} and o_err  out  1 (reserved op).

Function
REQ-013 The block SHALL implement states IDLE -> LO -> HI -> WB -> DONE -> IDLE, each transition unconditional except IDLE.
REQ-014 IDLE SHALL assert o_ready=1; on i_valid, it SHALL latch i_op, i_a, i_b and i_z_prev and go to LO, and it SHALL assert o_ready=0 in every other state.
REQ-015 LO SHALL drive the low bytes with control 000 (ADD) for ADD16/ADD_E8 or 010 (SUB) for SUB16.
REQ-016 HI SHALL drive the high bytes with control 001 (ADC) or 011 (SBC), use the ALU's internally held carry, and capture i_alu_data/i_alu_flags as the low-byte result.
REQ-017 For ADD_E8 in HI, o_alu_b SHALL be 0xFF if i_b[7]=1, else 0x00.
REQ-018 WB SHALL capture the high-byte result and flags.
REQ-019 DONE SHALL assert o_valid=1 for exactly one cycle; o_result, o_flags and o_err SHALL hold until the next DONE.
REQ-020 The latency SHALL be o_valid four cycles after the accept edge, with throughput of one request per 5 cycles.
REQ-021 ADD16 flags SHALL be Z=latched i_z_prev, N=0, H and CY from the high byte.
REQ-022 SUB16 flags SHALL be Z=1 iff the 16-bit result is 0, N=1, H and CY from the high byte.
REQ-023 ADD_E8 flags SHALL be Z=0, N=0, H and CY from the low byte.
REQ-024 A reserved op SHALL go IDLE -> DONE directly with o_result=i_a, o_flags={i_z_prev,3'b000} and o_err=1; otherwise o_err=0.
REQ-025 In IDLE, DONE and WB, o_alu_control SHALL be 000 with o_alu_a and o_alu_b at 0x00.
REQ-026 Arithmetic SHALL wrap modulo 2^16 with no overflow output.
REQ-027 i_valid asserted outside IDLE SHALL be ignored and not queued.

Reset
REQ-028 i_rst SHALL force IDLE at the next edge regardless of state, including mid-operation, and no o_valid SHALL follow for the aborted request.
REQ-029 Reset values SHALL be: o_ready=1, o_valid=0, o_result=0x0000, o_flags=0x0, o_err=0, o_alu_a=0x00, o_alu_b=0x00, o_alu_control=000.

Configuration
REQ-030 The macro ALU16_SEQ_SUB_EN SHALL control SUB16: when defined, op 01 executes SUB16; when undefined, op 01 is handled as reserved per REQ-024.

Structure
REQ-031 Shared package gb80_pkg SHALL hold the ALU control encodings (ADD..CP), the op16 encodings, the flag bit indices Z=3/N=2/H=1/CY=0 and the sequencer state typedef.
REQ-032 The block SHALL have no sub-module; the existing 8-bit ALU SHALL be instantiated beside it at the parent level, and the bench SHALL instantiate both.

Verification
REQ-033 ADD16 a=0x0FFF, b=0x0001, z_prev=1 -> o_result=0x1000, o_flags=4'b1010, o_valid four cycles after accept.
REQ-034 ADD16 a=0xFFFF, b=0x0001, z_prev=0 -> o_result=0x0000, o_flags=4'b0011.
REQ-035 ADD_E8 a=0xFFF8, b=0x0008 -> o_result=0x0000, o_flags=4'b0011; a=0x0005, b=0x00FF -> o_result=0x0004.
REQ-036 SUB16 a=0x0001, b=0x0001 -> o_result=0x0000, Z=1, N=1, CY=0; with ALU16_SEQ_SUB_EN undefined -> o_err=1, o_result=0x0001 one cycle after accept.
REQ-037 i_rst pulsed while in HI -> next cycle o_ready=1 and all outputs at reset values, with no o_valid within the following 10 cycles.
REQ-038 i_valid held high for two requests -> o_ready low for 4 cycles between accepts and exactly two o_valid pulses 5 cycles apart.
